// File: rtl/bus_arbiter.sv
// Two-master, one-slave classic-cycle arbiter for the bexkat1 memory bus.
// Grant is held per transaction; a watchdog aborts transactions that never see s_ack_i.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        m0_cyc_i,
   input  logic [31:0] m0_adr_i,
   input  logic [3:0]  m0_sel_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_adr_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_we_o,
   output logic [31:0] s_adr_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  gnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic own0, own1, own_cyc, other_cyc, timeout, boundary;

   always_comb begin
      own0      = (state_q == OWN0);
      own1      = (state_q == OWN1);
      own_cyc   = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
      other_cyc = (own0 & m1_cyc_i) | (own1 & m0_cyc_i);
      timeout   = own_cyc & (cnt_q == CNT_LAST) & ~s_ack_i;
      boundary  = own_cyc & (s_ack_i | timeout);

      // An owner that drops cyc (flush) is rearbitrated exactly like IDLE.
      state_d = state_q;
      if (!own_cyc) begin
         if (m1_cyc_i)      state_d = OWN1;
         else if (m0_cyc_i) state_d = OWN0;
         else               state_d = IDLE;
      end else if (boundary && other_cyc) begin
         state_d = own0 ? OWN1 : OWN0;
      end

      cnt_d = '0;
      if (own_cyc && !s_ack_i && !timeout) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      gnt_o    = {own1, own0};

      s_cyc_o  = own_cyc;
      s_we_o   = own1 & m1_we_i;
      s_adr_o  = own1 ? m1_adr_i : (own0 ? m0_adr_i : '0);
      s_sel_o  = own1 ? m1_sel_i : (own0 ? m0_sel_i : '0);
      s_dat_o  = own1 ? m1_dat_i : '0;

      m0_ack_o = own0 & m0_cyc_i & s_ack_i;
      m1_ack_o = own1 & m1_cyc_i & s_ack_i;
      m0_err_o = own0 & timeout;
      m1_err_o = own1 & timeout;
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the bexkat1 pipeline memory bus. Shares the single classic-cycle bus (cyc/we/sel/adr/dat/ack) between the instruction-fetch master (m0) and the mem stage master (m1).
- Grant is registered and held for a whole transaction, which ends at ack or timeout. Ack is routed only to the owner.
- A watchdog aborts hung transactions with an error pulse so that mem-stage stalls always terminate.

Parameters:
- TIMEOUT, 255: cycles an owner may wait for s_ack before an abort; legal range 2..65535.
- CNT_W, 16: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m0_cyc_i  in  1  fetch request/cycle
- m0_adr_i  in  32  fetch address
- m0_sel_i  in  4  fetch byte lanes
- m0_ack_o  out  1  fetch ack
- m0_err_o  out  1  fetch timeout abort
- m0_dat_o  out  32  fetch read data
- m1_cyc_i  in  1  mem-stage cycle
- m1_we_i  in  1  mem-stage write enable
- m1_adr_i  in  32  mem-stage address
- m1_sel_i  in  4  mem-stage byte lanes
- m1_dat_i  in  32  mem-stage write data
- m1_ack_o  out  1  mem-stage ack
- m1_err_o  out  1  mem-stage timeout abort
- m1_dat_o  out  32  mem-stage read data
- s_cyc_o  out  1  slave cycle
- s_we_o  out  1  slave write enable
- s_adr_o  out  32  slave address
- s_sel_o  out  4  slave byte lanes
- s_dat_o  out  32  slave write data
- s_ack_i  in  1  slave ack
- s_dat_i  in  32  slave read data
- gnt_o  out  2  one-hot current owner ({m1,m0}); 00 when idle

Behaviour:
- Reset: asynchronous on rst_ni low.
  - State IDLE; gnt_o=00; watchdog=0; last-owner=m0.
  - All slave outputs are 0 combinationally, because no owner is selected.
  - Both acks and both errs are 0.
- States: IDLE, OWN0, OWN1. gnt_o decodes directly from state.
- IDLE:
  - m1_cyc_i -> OWN1.
  - else m0_cyc_i -> OWN0.
  - else stay in IDLE.
  - Grant latency is 1 cycle from request to s_cyc_o.
- OWNx slave drive (combinational from the owner):
  - s_cyc_o = mx_cyc_i; s_adr_o/s_sel_o forwarded from the owner.
  - s_we_o = m1_we_i when owner is m1; 0 when owner is m0.
  - s_dat_o = m1_dat_i when owner is m1; 0 when owner is m0.
- OWNx ack/data routing:
  - mx_ack_o = s_ack_i & mx_cyc_i. The non-owner's ack is always 0.
  - m0_dat_o and m1_dat_o both carry s_dat_i; only the ack qualifies the data.
- Transaction boundary: any cycle in OWNx with mx_cyc_i & (s_ack_i | timeout). Next state at a boundary:
  - If the other master's cyc is high, switch to the other master (alternation guarantees no starvation).
  - Else if the owner's cyc is still high, stay in OWNx (back-to-back fetch).
  - Else go to IDLE.
- Owner drops cyc without ack (pipeline flush, pc_set):
  - Next state is decided as in IDLE the same cycle; no error is raised.
  - The slave sees s_cyc_o fall immediately.
- Watchdog:
  - Counts cycles in OWNx with mx_cyc_i=1 and s_ack_i=0.
  - Clears on every boundary, on every cycle where the owner's cyc is low, and in IDLE.
  - timeout = (count == TIMEOUT-1) & ~s_ack_i.
  - On timeout, mx_err_o=1 for exactly that cycle, mx_ack_o=0, and the cycle is a boundary.
  - s_ack_i and timeout in the same cycle: ack wins and err stays 0.
- Never drive a grant change except at a boundary, owner-cyc-low, or from IDLE.
- gnt_o is never 11. No ack or err is ever delivered to a master whose cyc is low.
- Reset mid-transaction: outputs drop asynchronously. The slave must tolerate an abandoned cycle; no replay is performed.

Test Plan:
- Single fetch: m0_cyc=1 at adr 0x100, slave acks on the 3rd owned cycle -> gnt_o=01 one cycle after request; m0_ack_o pulses once with m0_dat_o=s_dat_i; m1_ack_o=0 throughout.
- Simultaneous request from IDLE, both cyc=1: m1 store 0xDEADBEEF to 0x2000, sel=0011 -> OWN1 first with s_we_o=1, s_dat_o=0xDEADBEEF, s_sel_o=0011; after ack, gnt_o=01 next cycle.
- Alternation: both masters hold cyc, slave acks every cycle -> gnt_o sequence 10,01,10,01; each master gets every other ack and neither starves.
- Timeout with TIMEOUT=4: m1 load, slave never acks -> m1_err_o=1 on the 4th owned cycle, m1_ack_o=0, watchdog returns to 0; if m0 is pending, gnt_o=01 next cycle.
- Ack on the final cycle: with TIMEOUT=4, slave acks exactly on the 4th cycle -> m1_ack_o=1 and m1_err_o=0.
- Flush and reset: m0 drops cyc before ack -> s_cyc_o=0 the same cycle, no ack or err, IDLE next cycle. Asserting rst_ni=0 mid-OWN1 -> gnt_o=00 and s_cyc_o=0 asynchronously; the first request after release is granted after 1 cycle.
